// File: rtl/fir_pkg.sv
// Shared constants, state encoding and reset coefficient set for the serial FIR.
package fir_pkg;

  localparam int NTAPS    = 16;
  localparam int DIN_W    = 10;
  localparam int COEF_W   = 8;
  localparam int ACC_W    = 22;
  localparam int DOUT_W   = 11;
  localparam int DOUT_LSB = 5;

  // Tap index / pointer width; the history ring relies on NTAPS being a power of two
  localparam int TAP_W  = $clog2(NTAPS);
  localparam int PROD_W = DIN_W + COEF_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    OUT  = 2'd2
  } state_t;

  // Standard low-pass set, c0..c15 (sums to 64, so DC gain after the /32 slice is 2)
  localparam logic signed [COEF_W-1:0] DEF_COEF [NTAPS] = '{
    8'sd0,  8'sd0, 8'sd1,  -8'sd2, 8'sd2,  8'sd0, -8'sd7, 8'sd38,
    8'sd38, -8'sd7, 8'sd0, 8'sd2,  -8'sd2, 8'sd1, 8'sd0,  8'sd0
  };

endpackage

// File: rtl/fir_coef_rf.sv
// Coefficient register file: one synchronous write port, one combinational
// read port, reloads the default low-pass set on reset.
module fir_coef_rf
  import fir_pkg::*;
(
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_we,
  input  logic [TAP_W-1:0]         i_waddr,
  input  logic signed [COEF_W-1:0] i_wdata,
  input  logic [TAP_W-1:0]         i_raddr,
  output logic signed [COEF_W-1:0] o_rdata
);

  logic signed [COEF_W-1:0] r_mem [NTAPS];

  // Reset reload of the default set, otherwise single-port write
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < NTAPS; i++) begin
        r_mem[i] <= DEF_COEF[i];
      end
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/fir_serial_ctrl.sv
// Time-multiplexed 16-tap FIR: sample history ring, single MAC stepped over
// all taps, valid/ready on both sides, runtime-writable coefficient bank.
module fir_serial_ctrl
  import fir_pkg::*;
(
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic signed [DIN_W-1:0]  i_din,
  input  logic                     i_din_valid,
  output logic                     o_din_ready,
  output logic signed [DOUT_W-1:0] o_dout,
  output logic                     o_dout_valid,
  input  logic                     i_dout_ready,
  input  logic                     i_cfg_we,
  input  logic [3:0]               i_cfg_addr,
  input  logic signed [COEF_W-1:0] i_cfg_data,
  output logic                     o_cfg_err,
  output logic                     o_busy
);

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic signed [DIN_W-1:0]   r_hist [NTAPS];
  logic [TAP_W-1:0]          r_wr_ptr;
  logic [TAP_W-1:0]          r_k;
  logic [TAP_W-1:0]          w_rd_idx;
  logic signed [ACC_W-1:0]   r_acc;
  logic signed [ACC_W-1:0]   w_acc_nxt;
  logic signed [PROD_W-1:0]  w_prod;
  logic signed [COEF_W-1:0]  w_coef;
  logic signed [DOUT_W-1:0]  r_dout;
  logic                      r_dout_valid;
  logic                      r_din_ready;
  logic                      r_busy;
  logic                      r_cfg_err;
  logic                      w_accept;
  logic                      w_cfg_wr;
  logic                      w_last_tap;
  logic                      w_din_ready_nxt;
  logic                      w_dout_valid_nxt;
  logic                      w_busy_nxt;

  assign w_accept   = (r_state == IDLE) && i_din_valid;
  assign w_cfg_wr   = (r_state == IDLE) && i_cfg_we;
  assign w_last_tap = (r_k == TAP_W'(NTAPS - 1));

  // Newest sample sits just behind the write pointer; tap k walks back in time
  assign w_rd_idx  = r_wr_ptr - TAP_W'(1) - r_k;
  assign w_prod    = r_hist[w_rd_idx] * w_coef;
  assign w_acc_nxt = r_acc + {{(ACC_W - PROD_W){w_prod[PROD_W-1]}}, w_prod};

  fir_coef_rf u_coef_rf (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_we    (w_cfg_wr),
    .i_waddr (i_cfg_addr),
    .i_wdata (i_cfg_data),
    .i_raddr (r_k),
    .o_rdata (w_coef)
  );

  // FSM state register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    w_state_nxt = w_accept ? MAC : IDLE;
      MAC:     w_state_nxt = w_last_tap ? OUT : MAC;
      OUT:     w_state_nxt = i_dout_ready ? IDLE : OUT;
      default: w_state_nxt = IDLE;
    endcase
  end

  // FSM outputs, decoded from the upcoming state so the registered copies track it
  always_comb begin
    w_din_ready_nxt  = (w_state_nxt == IDLE);
    w_dout_valid_nxt = (w_state_nxt == OUT);
    w_busy_nxt       = (w_state_nxt == MAC) || (w_state_nxt == OUT);
  end

  // Registered handshake/status outputs; a rejected write pulses the error flag
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_din_ready  <= 1'b1;
      r_dout_valid <= 1'b0;
      r_busy       <= 1'b0;
      r_cfg_err    <= 1'b0;
    end else begin
      r_din_ready  <= w_din_ready_nxt;
      r_dout_valid <= w_dout_valid_nxt;
      r_busy       <= w_busy_nxt;
      r_cfg_err    <= i_cfg_we && (r_state != IDLE);
    end
  end

  // Datapath: history capture, tap stepping, accumulation and result slice
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < NTAPS; i++) begin
        r_hist[i] <= '0;
      end
      r_wr_ptr <= '0;
      r_k      <= '0;
      r_acc    <= '0;
      r_dout   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_k   <= '0;
          r_acc <= '0;
          if (w_accept) begin
            r_hist[r_wr_ptr] <= i_din;
            r_wr_ptr         <= r_wr_ptr + TAP_W'(1);
          end
        end
        MAC: begin
          r_acc <= w_acc_nxt;
          r_k   <= r_k + TAP_W'(1);
          if (w_last_tap) begin
            r_dout <= w_acc_nxt[DOUT_LSB+DOUT_W-1:DOUT_LSB];
          end
        end
        default: begin
          r_k <= '0;
        end
      endcase
    end
  end

  assign o_din_ready  = r_din_ready;
  assign o_dout       = r_dout;
  assign o_dout_valid = r_dout_valid;
  assign o_cfg_err    = r_cfg_err;
  assign o_busy       = r_busy;

endmodule

// File: tb/tb_fir_serial_ctrl.sv
// Self-checking bench for fir_serial_ctrl: impulse/step tables, backpressure,
// coefficient writes, mid-MAC reset and a random stream against a direct
// convolution model.
module tb_fir_serial_ctrl;
  import fir_pkg::*;

  logic                     clk = 1'b0;
  logic                     rst;
  logic signed [DIN_W-1:0]  din;
  logic                     din_valid;
  logic                     din_ready;
  logic signed [DOUT_W-1:0] dout;
  logic                     dout_valid;
  logic                     dout_ready;
  logic                     cfg_we;
  logic [3:0]               cfg_addr;
  logic signed [COEF_W-1:0] cfg_data;
  logic                     cfg_err;
  logic                     busy;

  always #5 clk = ~clk;

  fir_serial_ctrl dut (
    .i_clk(clk), .i_rst(rst), .i_din(din), .i_din_valid(din_valid),
    .o_din_ready(din_ready), .o_dout(dout), .o_dout_valid(dout_valid),
    .i_dout_ready(dout_ready), .i_cfg_we(cfg_we), .i_cfg_addr(cfg_addr),
    .i_cfg_data(cfg_data), .o_cfg_err(cfg_err), .o_busy(busy)
  );

  typedef struct { int din; int exp; } vec_t;

  localparam int DEF [16] = '{0, 0, 1, -2, 2, 0, -7, 38, 38, -7, 0, 2, -2, 1, 0, 0};

  int   n_tests = 0;
  int   n_fail  = 0;
  int   m_hist [16];   // m_hist[0] is the newest sample
  int   m_coef [16];
  vec_t imp_tbl [16];

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_hist[i] = 0;
      m_coef[i] = DEF[i];
    end
  endtask

  // y[n] = sum c_k * x[n-k], floor-divided by 32 and wrapped into 11 signed bits
  task automatic model_push(input int x, output int y);
    int acc;
    for (int i = 15; i > 0; i--) m_hist[i] = m_hist[i-1];
    m_hist[0] = x;
    acc = 0;
    for (int k = 0; k < 16; k++) acc += m_coef[k] * m_hist[k];
    y = (acc >>> 5) & 'h7FF;
    if (y >= 1024) y -= 2048;
  endtask

  task automatic do_reset();
    rst = 1'b1; din_valid = 1'b0; cfg_we = 1'b0; dout_ready = 1'b1;
    din = '0; cfg_addr = '0; cfg_data = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // Offer x, wait for acceptance, then wait for and consume the result (dout_ready=1)
  task automatic send_and_get(input int x, output int got, output int lat);
    int t;
    din = DIN_W'(x);
    din_valid = 1'b1;
    t = 0;
    while (!din_ready && t < 200) begin @(negedge clk); t++; end
    if (t >= 200) timeout("accept");
    @(negedge clk);
    din_valid = 1'b0;
    lat = 1;
    while (!dout_valid && lat < 100) begin @(negedge clk); lat++; end
    if (lat >= 100) timeout("result");
    got = int'(dout);
    @(negedge clk);
  endtask

  task automatic run_table(input string name, input int zero_a, input int zero_b);
    int got, lat, y, e;
    for (int i = 0; i < 16; i++) begin
      send_and_get(imp_tbl[i].din, got, lat);
      model_push(imp_tbl[i].din, y);
      e = (i == zero_a || i == zero_b) ? 0 : imp_tbl[i].exp;
      check($sformatf("%s[%0d]", name, i), got, e);
      check($sformatf("%s_model[%0d]", name, i), got, y);
      if (i == 0) check($sformatf("%s_latency", name), lat, NTAPS + 1);
    end
  endtask

  task automatic run_dc(input int v);
    int got, lat, y;
    for (int i = 0; i < 16; i++) begin
      send_and_get(v, got, lat);
      model_push(v, y);
      check($sformatf("dc%0d_model[%0d]", v, i), got, y);
      if (i >= 13) check($sformatf("dc%0d[%0d]", v, i), got, 2 * v);
    end
  endtask

  initial begin
    int got, lat, y, t, d0, vcount, last_acc, n_res, cyc;
    int exp_q[$];
    int acc_q[$];
    int imp_exp [16] = '{0, 0, 3, -7, 6, 0, -22, 118, 118, -22, 0, 6, -7, 3, 0, 0};
    for (int i = 0; i < 16; i++) begin
      imp_tbl[i].din = (i == 0) ? 100 : 0;
      imp_tbl[i].exp = imp_exp[i];
    end

    // Reset state
    do_reset();
    check("rst_din_ready", int'(din_ready), 1);
    check("rst_dout_valid", int'(dout_valid), 0);
    check("rst_dout", int'(dout), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_cfg_err", int'(cfg_err), 0);

    // Impulse and DC steps
    run_table("impulse", -1, -1);
    run_dc(100);
    run_dc(511);
    run_dc(-512);

    // Backpressure: result held 10 cycles with a pending sample waiting
    dout_ready = 1'b0;
    din = DIN_W'(77); din_valid = 1'b1;
    t = 0;
    while (!din_ready && t < 200) begin @(negedge clk); t++; end
    @(negedge clk);
    din = DIN_W'(-33);
    t = 0;
    while (!dout_valid && t < 100) begin @(negedge clk); t++; end
    if (t >= 100) timeout("bp_result");
    model_push(77, y);
    d0 = int'(dout);
    check("bp_result", d0, y);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_dout_stable", int'(dout), d0);
      check("bp_dout_valid", int'(dout_valid), 1);
      check("bp_din_ready", int'(din_ready), 0);
    end
    dout_ready = 1'b1;
    @(negedge clk);
    check("bp_valid_drop", int'(dout_valid), 0);
    check("bp_idle_ready", int'(din_ready), 1);
    @(negedge clk);
    din_valid = 1'b0;
    check("bp_pending_taken", int'(busy), 1);
    check("bp_single_hs", int'(dout_valid), 0);
    t = 0;
    while (!dout_valid && t < 100) begin @(negedge clk); t++; end
    if (t >= 100) timeout("bp_pending_result");
    model_push(-33, y);
    check("bp_pending_result", int'(dout), y);
    @(negedge clk);

    // Coefficient reconfiguration in IDLE
    do_reset();
    cfg_we = 1'b1; cfg_addr = 4'd7; cfg_data = 8'sd0;
    @(negedge clk);
    check("cfg_idle_err", int'(cfg_err), 0);
    cfg_addr = 4'd8;
    @(negedge clk);
    cfg_we = 1'b0;
    check("cfg_idle_err2", int'(cfg_err), 0);
    m_coef[7] = 0; m_coef[8] = 0;
    run_table("reconf", 7, 8);

    // Write during MAC is rejected and flagged
    din = DIN_W'(50); din_valid = 1'b1;
    t = 0;
    while (!din_ready && t < 200) begin @(negedge clk); t++; end
    @(negedge clk);
    din_valid = 1'b0;
    cfg_we = 1'b1; cfg_addr = 4'd7; cfg_data = 8'sd20;
    @(negedge clk);
    cfg_we = 1'b0;
    check("cfg_mac_err_pulse", int'(cfg_err), 1);
    @(negedge clk);
    check("cfg_mac_err_clear", int'(cfg_err), 0);
    t = 0;
    while (!dout_valid && t < 100) begin @(negedge clk); t++; end
    if (t >= 100) timeout("cfg_mac_result");
    model_push(50, y);
    check("cfg_mac_result", int'(dout), y);
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      int x;
      x = int'($urandom_range(1023)) - 512;
      send_and_get(x, got, lat);
      model_push(x, y);
      check($sformatf("cfg_unchanged[%0d]", i), got, y);
    end

    // Reset at tap k=8 aborts the computation
    din = DIN_W'(123); din_valid = 1'b1;
    t = 0;
    while (!din_ready && t < 200) begin @(negedge clk); t++; end
    @(negedge clk);
    din_valid = 1'b0;
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    vcount = 0;
    for (int i = 0; i < 20; i++) begin
      if (dout_valid) vcount++;
      @(negedge clk);
    end
    check("midrst_no_valid", vcount, 0);
    check("midrst_dout", int'(dout), 0);
    check("midrst_din_ready", int'(din_ready), 1);
    run_table("post_rst", -1, -1);

    // Random stream with din_valid and dout_ready held high
    din = DIN_W'(int'($urandom_range(1023)) - 512);
    din_valid = 1'b1; dout_ready = 1'b1;
    n_res = 0; last_acc = -1; cyc = 0;
    while (n_res < 8 && cyc < 400) begin
      logic took;
      took = 1'b0;
      if (dout_valid) begin
        if (exp_q.size() > 0) begin
          check($sformatf("stream[%0d]", n_res), int'(dout), exp_q.pop_front());
          check($sformatf("stream_lat[%0d]", n_res), cyc - acc_q.pop_front(), NTAPS + 1);
        end else begin
          timeout("stream_unexpected_valid");
        end
        n_res++;
      end
      if (din_ready) begin
        model_push(int'(din), y);
        exp_q.push_back(y);
        acc_q.push_back(cyc);
        if (last_acc >= 0) check("stream_period", cyc - last_acc, NTAPS + 2);
        last_acc = cyc;
        took = 1'b1;
      end
      @(negedge clk);
      cyc++;
      if (took) din = DIN_W'(int'($urandom_range(1023)) - 512);
    end
    if (n_res < 8) timeout("stream");
    din_valid = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fir_serial_ctrl.md
Name: fir_serial_ctrl

Overview:
Sequencer for a time-multiplexed 16-tap FIR built around one multiplier-accumulator. It replaces the fully parallel synchronous filter where area matters.
- Accepts samples over a valid/ready handshake and keeps the sample history in a circular buffer.
- Steps the single MAC through all taps, then presents the scaled result over a valid/ready handshake.
- Holds a runtime-writable coefficient bank that resets to the team's standard low-pass set.

Parameters:
NTAPS, 16, number of taps; sets the history depth and the MAC cycle count
DIN_W, 10, signed input sample width
COEF_W, 8, signed coefficient width
ACC_W, 22, signed accumulator width (DIN_W+COEF_W+log2(NTAPS))
DOUT_W, 11, signed output width
DOUT_LSB, 5, accumulator bit mapped to dout[0]

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
din  in  DIN_W  signed input sample
din_valid  in  1  sample offered
din_ready  out  1  block can accept a sample
dout  out  DOUT_W  signed result, acc[DOUT_LSB+DOUT_W-1:DOUT_LSB]
dout_valid  out  1  result valid
dout_ready  in  1  downstream accepts result
cfg_we  in  1  coefficient write strobe
cfg_addr  in  4  coefficient index k
cfg_data  in  COEF_W  signed coefficient value
cfg_err  out  1  one-cycle pulse when a write is rejected
busy  out  1  high in MAC or OUT state

Behaviour:
- One clock (clk). Reset is synchronous, active-high (rst).
- On reset:
  - State goes to IDLE; history buffer cleared to 0; write pointer and tap counter set to 0; accumulator set to 0.
  - dout=0, dout_valid=0, cfg_err=0, busy=0, din_ready=1 from the first cycle after reset.
  - Coefficients reload to c0..c15 = 0,0,1,-2,2,0,-7,38,38,-7,0,2,-2,1,0,0.
- Reset asserted mid-operation aborts the computation. The result is discarded and dout_valid drops on the next cycle.
- IDLE state:
  - din_ready=1.
  - When din_valid=1, the sample is written at wr_ptr and wr_ptr increments, wrapping from NTAPS-1 to 0.
  - The accumulator is cleared and the state moves to MAC.
- MAC state: lasts exactly NTAPS cycles with tap counter k=0..NTAPS-1.
  - Each cycle: acc += hist[(newest-k) mod NTAPS] * c_k.
  - Tap k is the k-th most recent sample, so y[n] = sum c_k*x[n-k].
  - Products and accumulation are full-precision signed; no saturation within ACC_W.
  - After k=NTAPS-1, the state moves to OUT.
- OUT state:
  - dout_valid=1; dout is held stable until dout_ready=1.
  - On the dout_ready=1 cycle, the state moves to IDLE and dout_valid deasserts on the next cycle.
  - dout keeps its last value while dout_valid=0.
- din_ready=0 in MAC and OUT. A din_valid with din_ready=0 is not consumed; the upstream holds the sample.
- Timing, for a sample accepted at cycle T with dout_ready tied high:
  - dout_valid rises at T+NTAPS+1.
  - The next sample is accepted at T+NTAPS+2 or later.
- Output scaling: dout = acc[15:5] by bit slice, i.e. an arithmetic floor divide by 32. Bits above 15 are dropped, so overflow wraps, bit-exact with the parallel filter.
- Coefficient writes:
  - Accepted only in IDLE; the new value applies from the next accepted sample.
  - In MAC or OUT, the write is ignored and cfg_err pulses for one cycle.
  - A write in IDLE in the same cycle as a sample accept is accepted; that sample uses the new coefficient.
- busy=1 in MAC and OUT states.

Decomposition:
- Package fir_pkg holds:
  - width constants DIN_W, COEF_W, ACC_W, DOUT_W, DOUT_LSB and NTAPS;
  - the default coefficient array constant;
  - the state enum {IDLE, MAC, OUT}.
- Sub-module fir_coef_rf: NTAPS x COEF_W register file with one synchronous write port, one combinational read port, and reset load from the package default array.
- History buffer, pointers, MAC and FSM live in fir_serial_ctrl.

Test Plan:
- Impulse test: reset, then feed 100 followed by 15 zeros with dout_ready=1. Required dout sequence: 0,0,3,-7,6,0,-22,118,118,-22,0,6,-7,3,0,0.
- DC step: feed constant 100. dout reaches 200 from the 14th output onward. Constant 511 gives 1022; constant -512 gives -1024.
- Backpressure: hold dout_ready=0 for 10 cycles in OUT. dout and dout_valid must stay stable, din_ready=0, and a pending din_valid must not be consumed. Release: exactly one handshake, and the next sample is accepted the cycle after return to IDLE.
- Coefficient reconfiguration:
  - In IDLE, write c7=0 and c8=0, then run the impulse of 100. Outputs 7 and 8 must be 0; all others unchanged.
  - A write during MAC pulses cfg_err and leaves the coefficient unchanged.
- Reset mid-MAC: assert rst at k=8. Required: no dout_valid, history cleared, coefficients back to defaults, and a following impulse of 100 reproduces the impulse-test sequence.
- Latency and throughput: a random stream with din_valid and dout_ready held high gives one result every NTAPS+2 cycles, and each result matches a reference model of the parallel filter.
